pwm_gen: RTL and testbench

- Waveform generator that consumes the off-time divider produced by the PWM control loop.
- Each switching period is ON_TIME clocks high, then off_len clocks low; off_len is the sampled off_div, clamped.
- Pulses pwm_en once per period so the controller computes the next off_div.
- Samples the new off_div only when the controller reports pwm_rdy.

---
 rtl/pwm_gen.sv | 158 +++++++++++++++
 tb/tb_pwm_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// Fixed-on-time PWM generator: ON_TIME clocks high, then a clamped off-time
// taken from the controller's off_div, with a stretch while the controller is busy.
module pwm_gen #(
  parameter int ON_TIME    = 40,
  parameter int CNT_WIDTH  = 18,
  parameter int TOTAL_TIME = 400,
  parameter int MIN_OFF    = 1,
  parameter int PCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  run,
  input  logic [CNT_WIDTH-1:0]  off_div,
  input  logic                  pwm_rdy,
  output logic                  pwm_en,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic                  late,
  output logic [CNT_WIDTH-1:0]  off_len,
  output logic [PCNT_WIDTH-1:0] period_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ON_LAST  = CNT_WIDTH'(ON_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_TOP  = CNT_WIDTH'(TOTAL_TIME);
  localparam logic [CNT_WIDTH-1:0] OFF_MAX  = CNT_WIDTH'(TOTAL_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_MIN  = CNT_WIDTH'(MIN_OFF);

  state_t                  state, state_d;
  logic [CNT_WIDTH-1:0]    cnt, cnt_d;
  logic [CNT_WIDTH-1:0]    off_len_d;
  logic [CNT_WIDTH-1:0]    clamped;
  logic [PCNT_WIDTH-1:0]   period_cnt_d;
  logic                    stop, stop_d;
  logic                    pwm_out_d, pwm_en_d, period_start_d, late_d;
  logic                    start;

  // Off-time as it would be latched right now.
  always_comb begin
    if (off_div >= OFF_TOP) begin
      clamped = OFF_MAX;
    end else if (off_div < OFF_MIN) begin
      clamped = OFF_MIN;
    end else begin
      clamped = off_div;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    off_len_d      = off_len;
    period_cnt_d   = period_cnt;
    stop_d         = stop;
    pwm_out_d      = 1'b0;
    pwm_en_d       = 1'b0;
    period_start_d = 1'b0;
    late_d         = 1'b0;
    start          = 1'b0;

    unique case (state)
      IDLE: begin
        stop_d = 1'b0;
        if (run && pwm_rdy) begin
          start = 1'b1;
        end
      end

      ON: begin
        // A run drop mid-period is remembered so the period still finishes whole.
        if (!run) begin
          stop_d = 1'b1;
        end
        if (cnt == ON_LAST) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt + 1'b1;
          pwm_out_d = 1'b1;
        end
      end

      OFF: begin
        if (cnt == off_len - 1'b1) begin
          period_cnt_d = period_cnt + 1'b1;
          cnt_d        = '0;
          if (!run || stop) begin
            state_d = IDLE;
            stop_d  = 1'b0;
          end else if (pwm_rdy) begin
            start = 1'b1;
          end else begin
            state_d = WAIT;
            late_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
          if (!run) begin
            stop_d = 1'b1;
          end
        end
      end

      WAIT: begin
        if (!run) begin
          state_d = IDLE;
        end else if (pwm_rdy) begin
          start = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d        = ON;
      cnt_d          = '0;
      off_len_d      = clamped;
      stop_d         = 1'b0;
      pwm_out_d      = 1'b1;
      pwm_en_d       = 1'b1;
      period_start_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      off_len      <= '0;
      period_cnt   <= '0;
      stop         <= 1'b0;
      pwm_out      <= 1'b0;
      pwm_en       <= 1'b0;
      period_start <= 1'b0;
      late         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      off_len      <= off_len_d;
      period_cnt   <= period_cnt_d;
      stop         <= stop_d;
      pwm_out      <= pwm_out_d;
      pwm_en       <= pwm_en_d;
      period_start <= period_start_d;
      late         <= late_d;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: stimulus queues the expected shape of each
// period; a monitor measures every period between period_start pulses.
module tb_pwm_gen;

  localparam int CW = 18;
  localparam int PW = 16;

  logic          clk;
  logic          n_rst;
  logic          run;
  logic [CW-1:0] off_div;
  logic          pwm_rdy;
  logic          pwm_en;
  logic          pwm_out;
  logic          period_start;
  logic          late;
  logic [CW-1:0] off_len;
  logic [PW-1:0] period_cnt;

  pwm_gen dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .run          (run),
    .off_div      (off_div),
    .pwm_rdy      (pwm_rdy),
    .pwm_en       (pwm_en),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .late         (late),
    .off_len      (off_len),
    .period_cnt   (period_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int on_len;
    int low_len;
    int late_n;
    int pcnt;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic flush    = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Hand-computed table: off_div driven for each period, resulting off_len,
  // measured low cycles and late pulses. Period 7 is stretched by 10 WAIT
  // cycles; period 8 ends in IDLE and the monitor is flushed 16 cycles later.
  int divs  [9] = '{100, 100, 100, 500, 0, 100, 200, 100, 100};
  int lens  [9] = '{100, 100, 100, 399, 1, 100, 200, 100, 100};
  int lows  [9] = '{100, 100, 100, 399, 1, 100, 200, 110, 116};
  int lates [9] = '{0,   0,   0,   0,   0, 0,   0,   1,   0};

  task automatic push(input int i);
    exp_t e;
    e.on_len  = 40;
    e.low_len = lows[i];
    e.late_n  = lates[i];
    e.pcnt    = i;
    e.len     = lens[i];
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < bound);
    if (!period_start) check("start_timeout", 0, 1);
  endtask

  // Drop run on ON cycle 5; the period must finish (40 + 100) and then idle.
  task automatic stop_and_flush();
    int en_n = 0;
    wait_start(1000);
    repeat (5) @(negedge clk);
    run = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (pwm_en) en_n++;
    end
    check("idle_no_en", en_n, 0);
    check("idle_out", int'(pwm_out), 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Monitor: measures each period and compares it against the queue.
  int on_c, low_c, late_c, pcnt_c, len_c;
  bit in_period = 1'b0;

  task automatic finalize(input int on_n, input int low_n, input int late_n,
                          input int pcnt, input int len);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_period", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("on_len", on_n, e.on_len);
      check("low_len", low_n, e.low_len);
      check("late_pulses", late_n, e.late_n);
      check("period_cnt_at_start", pcnt, e.pcnt);
      check("off_len", len, e.len);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (!n_rst) begin
      in_period = 1'b0;
    end else begin
      if (pwm_en !== period_start) check("en_align", int'(pwm_en), int'(period_start));
      if (flush && in_period) begin
        finalize(on_c, low_c, late_c, pcnt_c, len_c);
        in_period = 1'b0;
      end
      if (period_start) begin
        if (in_period) finalize(on_c, low_c, late_c, pcnt_c, len_c);
        in_period = 1'b1;
        on_c   = 0;
        low_c  = 0;
        late_c = 0;
        pcnt_c = int'(period_cnt);
        len_c  = int'(off_len);
      end
      if (in_period) begin
        if (pwm_out) on_c++;
        else         low_c++;
        if (late)    late_c++;
      end
    end
  end

  initial begin
    int busy;
    n_rst   = 1'b0;
    run     = 1'b0;
    pwm_rdy = 1'b0;
    off_div = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_pwm_en", int'(pwm_en), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_late", int'(late), 0);
    check("rst_off_len", int'(off_len), 0);
    check("rst_period_cnt", int'(period_cnt), 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Back-to-back periods; off_div for the next period is set on ON cycle 5.
    off_div = CW'(divs[0]);
    run     = 1'b1;
    pwm_rdy = 1'b1;
    push(0);
    for (int i = 0; i < 8; i++) begin
      wait_start(1000);
      repeat (5) @(negedge clk);
      off_div = CW'(divs[i+1]);
      push(i + 1);
      if (i == 7) begin
        // Period 7: controller busy from cycle 60 until cycle 149 (10 past OFF).
        repeat (55) @(negedge clk);
        pwm_rdy = 1'b0;
        repeat (89) @(negedge clk);
        pwm_rdy = 1'b1;
      end
    end
    stop_and_flush();
    check("pcnt_after_stop", int'(period_cnt), 9);

    // Asynchronous reset in the middle of the ON phase.
    run = 1'b1;
    wait_start(1000);
    repeat (20) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("async_pwm_out", int'(pwm_out), 0);
    check("async_period_cnt", int'(period_cnt), 0);
    check("async_off_len", int'(off_len), 0);
    pwm_rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // run high but controller not ready: must stay idle.
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (pwm_en || pwm_out) busy++;
    end
    check("idle_wait_rdy", busy, 0);

    pwm_rdy = 1'b1;
    begin
      exp_t e;
      e.on_len  = 40;
      e.low_len = 116;
      e.late_n  = 0;
      e.pcnt    = 0;
      e.len     = 100;
      exp_q.push_back(e);
    end
    stop_and_flush();
    check("pcnt_after_reset", int'(period_cnt), 1);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
